// File: rtl/rbz_gpout_pkg.sv
// Shared types for the general-purpose output router: mode encodings, source ids, config record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rbz_gpout_pkg;

  // Width of the divider reload held in every config record.
  localparam int unsigned CFG_DIV_W = 8;

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_STICKY  = 2'b10,
    MODE_STRETCH = 2'b11
  } gpout_mode_e;

  // Source select ids.
  localparam logic [3:0] SRC_PRIMARY  = 4'd0;
  localparam logic [3:0] SRC_ALT      = 4'd1;
  localparam logic [3:0] SRC_CLK      = 4'd2;
  localparam logic [3:0] SRC_DIVCLK   = 4'd3;
  localparam logic [3:0] SRC_HPOS0    = 4'd4;
  localparam logic [3:0] SRC_HPOS1    = 4'd5;
  localparam logic [3:0] SRC_HPOS8    = 4'd6;
  localparam logic [3:0] SRC_HPOS9    = 4'd7;
  localparam logic [3:0] SRC_VPOS0    = 4'd8;
  localparam logic [3:0] SRC_VPOS1    = 4'd9;
  localparam logic [3:0] SRC_VPOS8    = 4'd10;
  localparam logic [3:0] SRC_VPOS9    = 4'd11;
  localparam logic [3:0] SRC_TEX_OEB0 = 4'd12;
  localparam logic [3:0] SRC_TEX_IN0  = 4'd13;
  localparam logic [3:0] SRC_VEC_CSB  = 4'd14;
  localparam logic [3:0] SRC_REG_CSB  = 4'd15;

  typedef struct packed {
    logic [3:0]           sel;
    gpout_mode_e          mode;
    logic [CFG_DIV_W-1:0] div;
  } gpout_cfg_t;

  // Sources shared by every channel; hpos/vpos carry bits {9,8,1,0}.
  typedef struct packed {
    logic       reg_csb;
    logic       vec_csb;
    logic       tex_in0;
    logic       tex_oeb0;
    logic [3:0] vpos;
    logic [3:0] hpos;
  } gpout_shared_t;

endpackage

// File: rtl/gpout_channel.sv
// One debug output channel: source mux, divider, edge detect, mode logic, shadow/active config.
// Latency: direct 0 cycles combinational, stateful modes update at the sampling edge; +1 when registered.
// Backpressure: none; config writes are always accepted and applied on the frame strobe.
// GPOUT_STRETCH_EN builds the pulse-stretch counter; without it mode 11 acts as direct.
module gpout_channel
  import rbz_gpout_pkg::*;
#(
  parameter int unsigned STRETCH_W = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_cfg_we,
  input  gpout_cfg_t    i_cfg,
  input  logic          i_frame_strobe,
  input  logic          i_clear,
  input  logic          i_reg_outs_enb,
  input  logic          i_primary,
  input  logic          i_alt,
  input  gpout_shared_t i_shared,
  output logic          o_gpout,
  output logic          o_pending
);

  gpout_cfg_t           shadow_q;
  gpout_cfg_t           active_q;
  logic                 pending_q;
  logic                 apply;
  logic [CFG_DIV_W-1:0] div_cnt_q;
  logic                 divclk_q;
  logic                 s_q;
  logic                 state_q;
  logic                 out_q;
  logic [15:0]          src;
  logic                 s;
  logic                 s_rise;
  logic                 stretch_act;
  logic                 out_c;
  gpout_mode_e          mode_eff;

  // Only channels with an outstanding write are touched by the frame strobe.
  assign apply     = i_frame_strobe & pending_q;
  assign o_pending = pending_q;

  // Shadow capture, frame-aligned apply; a write coinciding with the strobe stays pending.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (apply)
        active_q <= shadow_q;
      if (i_cfg_we)
        shadow_q <= i_cfg;
      if (i_cfg_we)
        pending_q <= 1'b1;
      else if (i_frame_strobe)
        pending_q <= 1'b0;
    end
  end

  // Divider: count 0..div, toggle divclk on wrap, restart on apply.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_cnt_q <= '0;
      divclk_q  <= 1'b0;
    end else if (apply) begin
      div_cnt_q <= '0;
      divclk_q  <= 1'b0;
    end else if (div_cnt_q == active_q.div) begin
      div_cnt_q <= '0;
      divclk_q  <= ~divclk_q;
    end else begin
      div_cnt_q <= div_cnt_q + CFG_DIV_W'(1);
    end
  end

  // Source table indexed by the active select.
  always_comb begin
    src               = '0;
    src[SRC_PRIMARY]  = i_primary;
    src[SRC_ALT]      = i_alt;
    src[SRC_CLK]      = i_clk;
    src[SRC_DIVCLK]   = divclk_q;
    src[SRC_HPOS0]    = i_shared.hpos[0];
    src[SRC_HPOS1]    = i_shared.hpos[1];
    src[SRC_HPOS8]    = i_shared.hpos[2];
    src[SRC_HPOS9]    = i_shared.hpos[3];
    src[SRC_VPOS0]    = i_shared.vpos[0];
    src[SRC_VPOS1]    = i_shared.vpos[1];
    src[SRC_VPOS8]    = i_shared.vpos[2];
    src[SRC_VPOS9]    = i_shared.vpos[3];
    src[SRC_TEX_OEB0] = i_shared.tex_oeb0;
    src[SRC_TEX_IN0]  = i_shared.tex_in0;
    src[SRC_VEC_CSB]  = i_shared.vec_csb;
    src[SRC_REG_CSB]  = i_shared.reg_csb;
  end

  assign s      = src[active_q.sel];
  assign s_rise = s & ~s_q;

  // Effective mode: the raw clock cannot be edge-detected, so it is always passed straight through.
  always_comb begin
    mode_eff = active_q.mode;
    if (active_q.sel == SRC_CLK)
      mode_eff = MODE_DIRECT;
`ifndef GPOUT_STRETCH_EN
    if (mode_eff == MODE_STRETCH)
      mode_eff = MODE_DIRECT;
`endif
  end

  // Edge history and toggle/sticky state; sticky set beats clear, clear beats toggle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s_q     <= 1'b0;
      state_q <= 1'b0;
    end else if (apply) begin
      s_q     <= 1'b0;
      state_q <= 1'b0;
    end else begin
      s_q <= s;
      case (mode_eff)
        MODE_TOGGLE: begin
          if (i_clear)
            state_q <= 1'b0;
          else if (s_rise)
            state_q <= ~state_q;
        end
        MODE_STICKY: begin
          if (s_rise)
            state_q <= 1'b1;
          else if (i_clear)
            state_q <= 1'b0;
        end
        default: begin
          if (i_clear)
            state_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef GPOUT_STRETCH_EN
  logic [STRETCH_W-1:0] stretch_q;

  // Stretch counter: an edge (re)loads the full count, then it drains to zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      stretch_q <= '0;
    else if (apply)
      stretch_q <= '0;
    else if ((mode_eff == MODE_STRETCH) && s_rise)
      stretch_q <= '1;
    else if (stretch_q != '0)
      stretch_q <= stretch_q - STRETCH_W'(1);
  end

  assign stretch_act = (stretch_q != '0);
`else
  assign stretch_act = 1'b0;
`endif

  // Conditioned output per effective mode.
  always_comb begin
    out_c = s;
    case (mode_eff)
      MODE_TOGGLE,
      MODE_STICKY:  out_c = state_q;
      MODE_STRETCH: out_c = stretch_act | s_rise;
      default:      out_c = s;
    endcase
  end

  // Optional output register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      out_q <= 1'b0;
    else
      out_q <= out_c;
  end

  assign o_gpout = i_reg_outs_enb ? out_c : out_q;

endmodule

// File: rtl/gpout_router.sv
// Routes CH debug outputs from 16 internal sources with per-channel mode and divider.
// Latency: 0 cycles combinational / 1 cycle registered; config lands at the next frame strobe.
// Backpressure: none; writes to channels >= CH are dropped. Optional feature macro: GPOUT_STRETCH_EN.
module gpout_router
  import rbz_gpout_pkg::*;
#(
  parameter  int unsigned CH        = 3,
  parameter  int unsigned DIV_W     = 8,
  parameter  int unsigned STRETCH_W = 4,
  localparam int unsigned CH_W      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_cfg_we,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [3:0]       i_cfg_sel,
  input  logic [1:0]       i_cfg_mode,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic             i_frame_strobe,
  input  logic             i_clear,
  input  logic             i_reg_outs_enb,
  input  logic [CH-1:0]    i_primary,
  input  logic [CH-1:0]    i_alt,
  input  logic             i_vec_csb,
  input  logic             i_reg_csb,
  input  logic             i_tex_oeb0,
  input  logic [3:0]       i_tex_in,
  input  logic [9:0]       i_hpos,
  input  logic [9:0]       i_vpos,
  output logic [CH-1:0]    o_gpout,
  output logic             o_cfg_pending
);

  gpout_cfg_t    cfg_wr;
  gpout_shared_t shared;
  logic [CH-1:0] pending;
  logic          unused_bits;

  // Pack the write port into a config record; reloads wider than the record are truncated.
  always_comb begin
    cfg_wr      = '0;
    cfg_wr.sel  = i_cfg_sel;
    cfg_wr.mode = gpout_mode_e'(i_cfg_mode);
    cfg_wr.div  = CFG_DIV_W'(i_cfg_div);
  end

  // Gather the shared source bits every channel can select.
  always_comb begin
    shared          = '0;
    shared.hpos     = {i_hpos[9], i_hpos[8], i_hpos[1], i_hpos[0]};
    shared.vpos     = {i_vpos[9], i_vpos[8], i_vpos[1], i_vpos[0]};
    shared.tex_oeb0 = i_tex_oeb0;
    shared.tex_in0  = i_tex_in[0];
    shared.vec_csb  = i_vec_csb;
    shared.reg_csb  = i_reg_csb;
  end

  assign unused_bits = ^{i_tex_in[3:1], i_hpos[7:2], i_vpos[7:2]};

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic wr_hit;
    assign wr_hit = i_cfg_we && (i_cfg_ch == CH_W'(c));

    gpout_channel #(
      .STRETCH_W (STRETCH_W)
    ) u_ch (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_cfg_we       (wr_hit),
      .i_cfg          (cfg_wr),
      .i_frame_strobe (i_frame_strobe),
      .i_clear        (i_clear),
      .i_reg_outs_enb (i_reg_outs_enb),
      .i_primary      (i_primary[c]),
      .i_alt          (i_alt[c]),
      .i_shared       (shared),
      .o_gpout        (o_gpout[c]),
      .o_pending      (pending[c])
    );
  end

  assign o_cfg_pending = |pending;

endmodule

// File: tb/tb_gpout_router.sv
// Directed vector bench for gpout_router (CH=3, DIV_W=8, STRETCH_W=4).
// Each vector drives one cycle of inputs at the falling edge and checks outputs 2 time units later.
// Stretch expectations follow GPOUT_STRETCH_EN.
module tb_gpout_router;

  logic       i_clk;
  logic       i_reset_n;
  logic       i_cfg_we;
  logic [1:0] i_cfg_ch;
  logic [3:0] i_cfg_sel;
  logic [1:0] i_cfg_mode;
  logic [7:0] i_cfg_div;
  logic       i_frame_strobe;
  logic       i_clear;
  logic       i_reg_outs_enb;
  logic [2:0] i_primary;
  logic [2:0] i_alt;
  logic       i_vec_csb;
  logic       i_reg_csb;
  logic       i_tex_oeb0;
  logic [3:0] i_tex_in;
  logic [9:0] i_hpos;
  logic [9:0] i_vpos;
  logic [2:0] o_gpout;
  logic       o_cfg_pending;

  int n_vec = 0;
  int n_err = 0;

  gpout_router #(
    .CH        (3),
    .DIV_W     (8),
    .STRETCH_W (4)
  ) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_cfg_we       (i_cfg_we),
    .i_cfg_ch       (i_cfg_ch),
    .i_cfg_sel      (i_cfg_sel),
    .i_cfg_mode     (i_cfg_mode),
    .i_cfg_div      (i_cfg_div),
    .i_frame_strobe (i_frame_strobe),
    .i_clear        (i_clear),
    .i_reg_outs_enb (i_reg_outs_enb),
    .i_primary      (i_primary),
    .i_alt          (i_alt),
    .i_vec_csb      (i_vec_csb),
    .i_reg_csb      (i_reg_csb),
    .i_tex_oeb0     (i_tex_oeb0),
    .i_tex_in       (i_tex_in),
    .i_hpos         (i_hpos),
    .i_vpos         (i_vpos),
    .o_gpout        (o_gpout),
    .o_cfg_pending  (o_cfg_pending)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic       we;
    logic [1:0] ch;
    logic [3:0] sel;
    logic [1:0] mode;
    logic [7:0] div;
    logic       strobe;
    logic       clear;
    logic       reg_enb;
    logic [2:0] primary;
    logic [2:0] alt;
    logic       vec;
    logic [2:0] exp_out;
    logic [2:0] msk;
    logic       exp_pend;
  } vec_t;

  function automatic vec_t mk(
    input logic we, input logic [1:0] ch, input logic [3:0] sel, input logic [1:0] mode,
    input logic [7:0] div, input logic strobe, input logic clear, input logic reg_enb,
    input logic [2:0] primary, input logic [2:0] alt, input logic vec,
    input logic [2:0] exp_out, input logic [2:0] msk, input logic exp_pend);
    vec_t t;
    t.we = we; t.ch = ch; t.sel = sel; t.mode = mode; t.div = div;
    t.strobe = strobe; t.clear = clear; t.reg_enb = reg_enb;
    t.primary = primary; t.alt = alt; t.vec = vec;
    t.exp_out = exp_out; t.msk = msk; t.exp_pend = exp_pend;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    i_cfg_we       = t.we;
    i_cfg_ch       = t.ch;
    i_cfg_sel      = t.sel;
    i_cfg_mode     = t.mode;
    i_cfg_div      = t.div;
    i_frame_strobe = t.strobe;
    i_clear        = t.clear;
    i_reg_outs_enb = t.reg_enb;
    i_primary      = t.primary;
    i_alt          = t.alt;
    i_vec_csb      = t.vec;
  endtask

  task automatic compare(input string nm, input vec_t t);
    n_vec++;
    if ((((o_gpout ^ t.exp_out) & t.msk) !== 3'b000) || (o_cfg_pending !== t.exp_pend)) begin
      n_err++;
      $display("FAIL %s: got gpout=%b pending=%b, want gpout=%b (mask %b) pending=%b",
               nm, o_gpout, o_cfg_pending, t.exp_out, t.msk, t.exp_pend);
    end
  endtask

  task automatic run(input vec_t t, input string nm);
    @(negedge i_clk);
    drive(t);
    #2;
    compare(nm, t);
  endtask

  task automatic run_tbl(input vec_t tbl[$], input string grp);
    foreach (tbl[i]) run(tbl[i], $sformatf("%s[%0d]", grp, i));
  endtask

  vec_t basic[$];
  vec_t sticky[$];
  vec_t toggle[$];
  vec_t stretch_cfg[$];
  vec_t collide[$];

  initial begin
    // we ch sel mode div  strobe clear reg  primary alt vec  exp msk pend
    basic.push_back(mk(0,0,0,0,0, 0,0,1, 3'b010,3'b000,0, 3'b010,3'b111,0));
    basic.push_back(mk(0,0,0,0,0, 0,0,0, 3'b010,3'b000,0, 3'b010,3'b111,0));
    basic.push_back(mk(0,0,0,0,0, 0,0,0, 3'b111,3'b000,0, 3'b010,3'b111,0));
    basic.push_back(mk(0,0,0,0,0, 0,0,0, 3'b111,3'b000,0, 3'b111,3'b111,0));
    basic.push_back(mk(1,1,3,0,2, 0,0,1, 3'b000,3'b000,0, 3'b000,3'b111,0));
    basic.push_back(mk(0,0,0,0,0, 0,0,1, 3'b000,3'b000,0, 3'b000,3'b111,1));
    basic.push_back(mk(1,3,1,0,0, 0,0,1, 3'b000,3'b000,0, 3'b000,3'b111,1));
    basic.push_back(mk(0,0,0,0,0, 1,0,1, 3'b000,3'b000,0, 3'b000,3'b111,1));

    sticky.push_back(mk(1,0,14,2,0, 0,0,1, 3'b000,3'b000,0, 3'b000,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  1,0,1, 3'b000,3'b000,0, 3'b000,3'b101,1));
    sticky.push_back(mk(0,0,0,0,0,  0,0,1, 3'b000,3'b000,0, 3'b000,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  0,0,1, 3'b000,3'b000,1, 3'b000,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  0,0,1, 3'b000,3'b000,1, 3'b001,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  0,0,1, 3'b000,3'b000,0, 3'b001,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  0,0,1, 3'b000,3'b000,0, 3'b001,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  0,1,1, 3'b000,3'b000,0, 3'b001,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  0,0,1, 3'b000,3'b000,0, 3'b000,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  0,0,1, 3'b000,3'b000,1, 3'b000,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  0,0,1, 3'b000,3'b000,0, 3'b001,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  0,1,1, 3'b000,3'b000,1, 3'b001,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  0,0,1, 3'b000,3'b000,1, 3'b001,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  0,1,1, 3'b000,3'b000,1, 3'b001,3'b101,0));
    sticky.push_back(mk(0,0,0,0,0,  0,0,1, 3'b000,3'b000,0, 3'b000,3'b101,0));

    toggle.push_back(mk(1,2,1,1,0, 0,0,1, 3'b000,3'b000,0, 3'b000,3'b100,0));
    toggle.push_back(mk(0,0,0,0,0, 1,0,1, 3'b000,3'b000,0, 3'b000,3'b100,1));
    toggle.push_back(mk(0,0,0,0,0, 0,0,1, 3'b000,3'b100,0, 3'b000,3'b100,0));
    toggle.push_back(mk(0,0,0,0,0, 0,0,1, 3'b000,3'b000,0, 3'b100,3'b100,0));
    toggle.push_back(mk(0,0,0,0,0, 0,0,1, 3'b000,3'b100,0, 3'b100,3'b100,0));
    toggle.push_back(mk(0,0,0,0,0, 0,0,1, 3'b000,3'b000,0, 3'b000,3'b100,0));

    stretch_cfg.push_back(mk(1,2,1,3,0, 0,0,1, 3'b000,3'b000,0, 3'b000,3'b100,0));
    stretch_cfg.push_back(mk(0,0,0,0,0, 1,0,1, 3'b000,3'b000,0, 3'b000,3'b100,1));

    collide.push_back(mk(1,1,0,0,0, 0,0,1, 3'b000,3'b000,0, 3'b000,3'b101,0));
    collide.push_back(mk(1,0,1,0,0, 1,0,1, 3'b000,3'b000,0, 3'b000,3'b101,1));
    collide.push_back(mk(0,0,0,0,0, 0,0,1, 3'b010,3'b001,0, 3'b010,3'b111,1));
    collide.push_back(mk(0,0,0,0,0, 1,0,1, 3'b010,3'b001,0, 3'b010,3'b111,1));
    collide.push_back(mk(0,0,0,0,0, 0,0,1, 3'b010,3'b001,0, 3'b011,3'b111,0));

    i_reset_n  = 1'b0;
    i_reg_csb  = 1'b0;
    i_tex_oeb0 = 1'b0;
    i_tex_in   = 4'h0;
    i_hpos     = 10'h0;
    i_vpos     = 10'h0;
    drive(mk(0,0,0,0,0, 0,0,0, 3'b000,3'b000,0, 3'b000,3'b000,0));

    // Reset state, registered then combinational.
    run(mk(0,0,0,0,0, 0,0,0, 3'b101,3'b000,0, 3'b000,3'b111,0), "reset_reg");
    run(mk(0,0,0,0,0, 0,0,1, 3'b101,3'b000,0, 3'b101,3'b111,0), "reset_comb");
    i_reset_n = 1'b1;

    run_tbl(basic, "basic");

    // ch1 divided clock, div=2: 6-cycle period starting low after the strobe.
    for (int k = 0; k < 12; k++) begin
      logic d;
      d = ((k / 3) % 2) == 1;
      run(mk(0,0,0,0,0, 0,0,1, 3'b000,3'b000,0, {1'b0, d, 1'b0}, 3'b111, 0),
          $sformatf("divclk[%0d]", k));
    end

    run_tbl(sticky, "sticky");
    run_tbl(toggle, "toggle");
    run_tbl(stretch_cfg, "stretch_cfg");

    // ch2 stretch on alt: pulses at cycles 0 and 10.
    for (int k = 0; k < 30; k++) begin
      logic a;
      logic e;
      a = (k == 0) || (k == 10);
`ifdef GPOUT_STRETCH_EN
      e = (k <= 25);
`else
      e = a;
`endif
      run(mk(0,0,0,0,0, 0,0,1, 3'b000,{a, 2'b00},0, {e, 2'b00}, 3'b100, 0),
          $sformatf("stretch[%0d]", k));
    end

    run_tbl(collide, "collide");

    // Async reset in the middle of a div=5 run, with a pending write outstanding.
    run(mk(1,1,3,0,5, 0,0,0, 3'b000,3'b000,0, 3'b011,3'b111,0), "rst_cfg");
    run(mk(0,0,0,0,0, 1,0,0, 3'b000,3'b000,0, 3'b000,3'b111,1), "rst_strobe");
    for (int k = 0; k < 8; k++) begin
      logic w;
      w = (k == 2);
      run(mk(w,2,5,0,0, 0,0,0, 3'b000,3'b000,0, {1'b0, (k == 7), 1'b0}, 3'b111, (k >= 3)),
          $sformatf("rst_div[%0d]", k));
    end
    #1 i_reset_n = 1'b0;
    #1 compare("async_reset", mk(0,0,0,0,0, 0,0,0, 3'b000,3'b000,0, 3'b000,3'b111,0));
    run(mk(0,0,0,0,0, 0,0,1, 3'b101,3'b000,0, 3'b101,3'b111,0), "rst_cfg_default");
    i_reset_n = 1'b1;
    run(mk(0,0,0,0,0, 0,0,1, 3'b101,3'b000,0, 3'b101,3'b111,0), "post_rst_default");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
